// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - execute/load writeback sources and register-file write port bundle
interface wb_port_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int EW    = 21,
  parameter int VW    = 192,
  parameter int RW    = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          ex_valid;
  logic          ex_ready;
  logic [RW-1:0] ex_dest;
  logic          ex_type;
  logic [EW-1:0] ex_data_e;
  logic [VW-1:0] ex_data_v;

  logic          mem_valid;
  logic          mem_ready;
  logic [RW-1:0] mem_dest;
  logic          mem_type;
  logic [VW-1:0] mem_data;

  logic          rf_we;
  logic [RW-1:0] rf_dest;
  logic          rf_type;
  logic [EW-1:0] rf_data_e;
  logic [VW-1:0] rf_data_v;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  ex_valid, ex_dest, ex_type, ex_data_e, ex_data_v,
    input  mem_valid, mem_dest, mem_type, mem_data,
    output ex_ready, mem_ready,
    output rf_we, rf_dest, rf_type, rf_data_e, rf_data_v, fifo_count
  );

  modport master (
    output ex_valid, ex_dest, ex_type, ex_data_e, ex_data_v,
    output mem_valid, mem_dest, mem_type, mem_data,
    input  ex_ready, mem_ready,
    input  rf_we, rf_dest, rf_type, rf_data_e, rf_data_v, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares one register-file write port between execute results and buffered load returns
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int EW           = 21,
  parameter int VW           = 192,
  parameter int RW           = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [RW-1:0] r_fifo_dest [DEPTH];
  logic          r_fifo_type [DEPTH];
  logic [VW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_wait_cnt;

  logic          r_rf_we;
  logic [RW-1:0] r_rf_dest;
  logic          r_rf_type;
  logic [EW-1:0] r_rf_data_e;
  logic [VW-1:0] r_rf_data_v;

  logic          w_head_v;
  logic          w_force;
  logic          w_gnt_ex;
  logic          w_gnt_mem;
  logic          w_full;
  logic          w_push;
  logic [RW-1:0] w_win_dest;
  logic          w_win_type;
  logic [EW-1:0] w_win_e;
  logic [VW-1:0] w_win_v;
  logic [SW-1:0] w_wait_nxt;
  logic [CW-1:0] w_count_nxt;

  // A head that has lost STARVE_LIMIT times in a row is forced through by refusing execute.
  always_comb begin
    w_head_v  = (r_count != '0);
    w_full    = (r_count == CW'(DEPTH));
    w_force   = w_head_v && (r_wait_cnt == SW'(STARVE_LIMIT));
    w_gnt_ex  = bus.ex_valid && !w_force;
    w_gnt_mem = w_head_v && !w_gnt_ex;
    w_push    = bus.mem_valid && !w_full;
  end

  always_comb begin
    w_win_dest = bus.ex_dest;
    w_win_type = bus.ex_type;
    w_win_e    = '0;
    w_win_v    = '0;
    if (!w_gnt_ex) begin
      w_win_dest = r_fifo_dest[r_rd_ptr];
      w_win_type = r_fifo_type[r_rd_ptr];
    end
    if (w_win_type) begin
      w_win_v = w_gnt_ex ? bus.ex_data_v : r_fifo_data[r_rd_ptr];
    end else begin
      w_win_e = w_gnt_ex ? bus.ex_data_e : r_fifo_data[r_rd_ptr][EW-1:0];
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!w_head_v || w_gnt_mem) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != SW'(STARVE_LIMIT)) begin
      w_wait_nxt = r_wait_cnt + 1'b1;
    end
    w_count_nxt = r_count;
    if (w_push && !w_gnt_mem) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_gnt_mem) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_wait_cnt  <= '0;
      r_rf_we     <= 1'b0;
      r_rf_dest   <= '0;
      r_rf_type   <= 1'b0;
      r_rf_data_e <= '0;
      r_rf_data_v <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rf_we    <= w_gnt_ex || w_gnt_mem;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_gnt_mem) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_gnt_ex || w_gnt_mem) begin
        r_rf_dest   <= w_win_dest;
        r_rf_type   <= w_win_type;
        r_rf_data_e <= w_win_e;
        r_rf_data_v <= w_win_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_fifo_dest[r_wr_ptr] <= bus.mem_dest;
      r_fifo_type[r_wr_ptr] <= bus.mem_type;
      r_fifo_data[r_wr_ptr] <= bus.mem_data;
    end
  end

  assign bus.ex_ready   = !w_force;
  assign bus.mem_ready  = !w_full;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_dest    = r_rf_dest;
  assign bus.rf_type    = r_rf_type;
  assign bus.rf_data_e  = r_rf_data_e;
  assign bus.rf_data_v  = r_rf_data_v;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int EW           = 21;
  localparam int VW           = 192;
  localparam int RW           = 4;

  logic clk;
  logic rst_n;

  wb_port_arbiter_if #(.DEPTH(DEPTH), .EW(EW), .VW(VW), .RW(RW)) bus ();

  wb_port_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .EW(EW), .VW(VW), .RW(RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [RW-1:0] dest;
    logic          typ;
    logic [EW-1:0] e;
    logic [VW-1:0] v;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [RW-1:0] dest;
    logic          typ;
    logic [VW-1:0] data;
  } ld_t;

  wr_t exp_q[$];
  ld_t ld_q[$];
  wr_t mon_w;
  ld_t m_ld;
  int  total = 0;
  int  bad = 0;
  int  cyc_n = 0;
  int  starve = 0;
  int  m_sz;
  bit  m_forced;
  bit  started = 0;
  bit  m_ex_acc = 0;
  bit  m_mem_acc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [RW-1:0] d, input logic t, input logic [EW-1:0] e,
                                input logic [VW-1:0] v, input int c);
    wr_t w;
    w.dest = d;
    w.typ  = t;
    w.e    = t ? '0 : e;
    w.v    = t ? v : '0;
    w.cyc  = c;
    return w;
  endfunction

  function automatic logic [VW-1:0] rnd_vw();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    cyc_n   = cyc_n + 1;
    started = 1;
  end

  // Reference model: one write-port grant per cycle, loads queued in order, execute
  // preferred unless the oldest load has already lost STARVE_LIMIT times.
  always @(negedge clk) begin
    if (started) begin
      m_sz     = ld_q.size();
      m_forced = (m_sz > 0) && (starve >= STARVE_LIMIT);
      chk("fifo_count", VW'(bus.fifo_count), VW'(m_sz));
      chk("mem_ready", VW'(bus.mem_ready), VW'(m_sz < DEPTH));
      chk("ex_ready", VW'(bus.ex_ready), VW'(!m_forced));
      if (!rst_n) begin
        ld_q.delete();
        starve    = 0;
        m_ex_acc  = 0;
        m_mem_acc = 0;
      end else begin
        m_ex_acc  = bus.ex_valid && !m_forced;
        m_mem_acc = bus.mem_valid && (m_sz < DEPTH);
        if (m_ex_acc) begin
          exp_q.push_back(mk_wr(bus.ex_dest, bus.ex_type, bus.ex_data_e, bus.ex_data_v, cyc_n + 1));
          if (m_sz > 0) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
        end else if (m_sz > 0) begin
          m_ld = ld_q.pop_front();
          exp_q.push_back(mk_wr(m_ld.dest, m_ld.typ, m_ld.data[EW-1:0], m_ld.data, cyc_n + 1));
          starve = 0;
        end
        if (m_sz == 0) starve = 0;
        if (m_mem_acc) begin
          m_ld.dest = bus.mem_dest;
          m_ld.typ  = bus.mem_type;
          m_ld.data = bus.mem_data;
          ld_q.push_back(m_ld);
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (started) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
        mon_w = exp_q.pop_front();
        chk("rf_we", VW'(bus.rf_we), VW'(1'b1));
        chk("rf_dest", VW'(bus.rf_dest), VW'(mon_w.dest));
        chk("rf_type", VW'(bus.rf_type), VW'(mon_w.typ));
        chk("rf_data_e", VW'(bus.rf_data_e), VW'(mon_w.e));
        chk("rf_data_v", bus.rf_data_v, mon_w.v);
      end else begin
        chk("rf_we_idle", VW'(bus.rf_we), '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ex_valid  = 0;
    bus.mem_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rnd_ex();
    bus.ex_dest   = RW'($urandom);
    bus.ex_type   = 1'($urandom);
    bus.ex_data_e = EW'($urandom);
    bus.ex_data_v = rnd_vw();
  endtask

  task automatic rnd_mem();
    bus.mem_dest = RW'($urandom);
    bus.mem_type = 1'($urandom);
    bus.mem_data = rnd_vw();
  endtask

  task automatic push_ld(input logic [RW-1:0] d, input logic t, input logic [VW-1:0] v, input string nm);
    int w = 0;
    bus.mem_dest  = d;
    bus.mem_type  = t;
    bus.mem_data  = v;
    bus.mem_valid = 1;
    do begin
      step();
      w++;
    end while (!m_mem_acc && w < 20);
    chk(nm, VW'(m_mem_acc), VW'(1'b1));
    bus.mem_valid = 0;
  endtask

  initial begin
    logic [VW-1:0] d3;
    bit exp_rdy[5];
    int pex_tab[4];
    int pmem_tab[4];
    exp_rdy  = '{1, 1, 1, 0, 1};
    pex_tab  = '{15, 60, 90, 100};
    pmem_tab = '{80, 40, 70, 30};
    d3       = {{188{1'b1}}, 4'h0};

    rst_n = 0;
    rnd_ex();
    rnd_mem();
    bus.ex_valid  = 1;
    bus.mem_valid = 1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_rf_we", VW'(bus.rf_we), '0);
    chk("reset_fifo_count", VW'(bus.fifo_count), '0);
    chk("reset_rf_data_v", bus.rf_data_v, '0);
    rst_n         = 1;
    bus.ex_valid  = 0;
    bus.mem_valid = 0;
    chk("post_reset_ex_ready", VW'(bus.ex_ready), VW'(1'b1));
    chk("post_reset_mem_ready", VW'(bus.mem_ready), VW'(1'b1));
    idle(2);

    bus.ex_dest   = 4'd5;
    bus.ex_type   = 1'b0;
    bus.ex_data_e = 21'h1ABCD;
    bus.ex_data_v = rnd_vw() | 192'd1;
    bus.ex_valid  = 1;
    step();
    bus.ex_valid = 0;
    #2;
    chk("ex_only_we", VW'(bus.rf_we), VW'(1'b1));
    chk("ex_only_dest", VW'(bus.rf_dest), VW'(4'd5));
    chk("ex_only_data_e", VW'(bus.rf_data_e), VW'(21'h1ABCD));
    chk("ex_only_data_v", bus.rf_data_v, '0);
    idle(2);

    push_ld(4'd3, 1'b1, d3, "load_only_accept");
    #2;
    chk("load_no_bypass", VW'(bus.rf_we), '0);
    step();
    #2;
    chk("load_we_n2", VW'(bus.rf_we), VW'(1'b1));
    chk("load_data_v", bus.rf_data_v, d3);
    chk("load_data_e", VW'(bus.rf_data_e), '0);
    idle(4);

    rnd_ex();
    bus.ex_valid = 1;
    push_ld(4'd7, 1'b0, rnd_vw(), "starve_accept");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("starve_ex_ready_%0d", i), VW'(bus.ex_ready), VW'(exp_rdy[i]));
      step();
    end
    idle(4);

    rnd_ex();
    bus.ex_valid = 1;
    for (int k = 0; k < 4; k++) push_ld(RW'(k + 8), 1'(k), rnd_vw(), "full_accept");
    chk("full_fifo_count", VW'(bus.fifo_count), VW'(DEPTH));
    chk("full_mem_ready", VW'(bus.mem_ready), '0);
    push_ld(4'd12, 1'b0, rnd_vw(), "fifth_accept");
    idle(12);

    rnd_ex();
    bus.ex_valid = 1;
    push_ld(4'd1, 1'b1, rnd_vw(), "burst_accept0");
    push_ld(4'd2, 1'b0, rnd_vw(), "burst_accept1");
    chk("burst_fifo_count", VW'(bus.fifo_count), VW'(2));
    rst_n = 0;
    step();
    rst_n        = 1;
    bus.ex_valid = 0;
    chk("midreset_fifo_count", VW'(bus.fifo_count), '0);
    chk("midreset_rf_we", VW'(bus.rf_we), '0);
    idle(6);

    for (int c = 0; c < 3000; c++) begin
      if (!(bus.ex_valid && !m_ex_acc)) begin
        bus.ex_valid = ($urandom_range(0, 99) < pex_tab[c / 750]);
        rnd_ex();
      end
      if (!(bus.mem_valid && !m_mem_acc)) begin
        bus.mem_valid = ($urandom_range(0, 99) < pmem_tab[c / 750]);
        rnd_mem();
      end
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1;
    idle(20);
    chk("drain_exp_empty", VW'(exp_q.size()), '0);
    chk("drain_fifo_count", VW'(bus.fifo_count), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
